// File: rtl/i2s_rx_slave_stream.sv
// i2s_rx_slave_stream
//   Slave I2S / left-justified receiver running directly on the codec bit
//   clock. It deserialises one DATA_W-bit word per lrck slot, MSB first, and
//   presents each completed left+right pair on a valid/ready stream.
//
// Ports:
//   bclk       in   bit clock, all logic on the rising edge
//   rst        in   synchronous reset, active-high
//   lrck       in   word select, 0 = left, 1 = right
//   sdata      in   serial data, MSB first
//   out_ready  in   downstream ready
//   clr_err    in   one-cycle pulse clearing the sticky flags
//   out_valid  out  stereo pair available
//   out_left   out  left sample
//   out_right  out  right sample
//   overrun    out  sticky, a pair was dropped while out_valid was held
//   short_err  out  sticky, a slot ended before DATA_W bits were captured
//   synced     out  receiver has seen its first left slot
//   dbg_state  out  current framing state (SYNC=0, LEFT=1, RIGHT=2)
//
// Stream handshake: a transfer happens on every rising edge where
// out_valid and out_ready are both 1. out_left/out_right never change while
// out_valid=1 and out_ready=0; a pair finishing in that situation is dropped.

module i2s_rx_slave_stream #(
    parameter int DATA_W = 16,
    parameter int MODE   = 0,
    parameter int CNT_W  = 6
) (
    input  logic              bclk,
    input  logic              rst,
    input  logic              lrck,
    input  logic              sdata,
    input  logic              out_ready,
    input  logic              clr_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              overrun,
    output logic              short_err,
    output logic              synced,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_e;

    state_e             state_q;
    logic               lrck_q;
    logic               edge_q;
    logic               active_q, active_d;
    logic               chan_q, chan_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  left_hold_q;

    logic               edge_now;
    logic               fall_now;
    logic               locked;
    logic               start;
    logic               word_done;
    logic               short_evt;
    logic [DATA_W-1:0]  word_val;
    logic               pair_done;

    assign edge_now = lrck ^ lrck_q;
    assign fall_now = edge_now & ~lrck;
    // The SYNC->LEFT edge itself already counts as locked so that in
    // left-justified mode the MSB sampled on that edge is not lost.
    assign locked   = (state_q != ST_SYNC) | fall_now;

    // Philips framing starts one bclk after the edge, left-justified on it.
    generate
        if (MODE == 1) begin : g_lj
            assign start = edge_now & locked;
        end else begin : g_i2s
            assign start = edge_q & (state_q != ST_SYNC);
        end
    endgenerate

    // Bits are written straight into their final position, so a word cut
    // short is already left-aligned with zero LSBs.
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        chan_d    = chan_q;
        word_done = 1'b0;
        short_evt = 1'b0;
        word_val  = '0;
        if (start) begin
            if (active_q) begin
                word_done = 1'b1;
                short_evt = 1'b1;
                word_val  = shreg_q;
            end
            shreg_d             = '0;
            shreg_d[DATA_W-1]   = sdata;
            cnt_d               = CNT_W'(1);
            active_d            = 1'b1;
            chan_d              = lrck;
        end else if (active_q) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (i == DATA_W - 1 - int'(cnt_q)) begin
                    shreg_d[i] = sdata;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                word_done = 1'b1;
                word_val  = shreg_d;
                active_d  = 1'b0;
            end
        end
    end

    // A finished word always belongs to the capture in flight (chan_q).
    assign pair_done = word_done & chan_q;

    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            lrck_q      <= 1'b0;
            edge_q      <= 1'b0;
            active_q    <= 1'b0;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            out_valid   <= 1'b0;
            out_left    <= '0;
            out_right   <= '0;
            overrun     <= 1'b0;
            short_err   <= 1'b0;
            synced      <= 1'b0;
        end else begin
            lrck_q   <= lrck;
            edge_q   <= edge_now;
            active_q <= active_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;

            case (state_q)
                ST_SYNC: begin
                    if (fall_now) begin
                        state_q <= ST_LEFT;
                        synced  <= 1'b1;
                    end
                end
                ST_LEFT: begin
                    if (edge_now && lrck) begin
                        state_q <= ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (fall_now) begin
                        state_q <= ST_LEFT;
                    end
                end
                default: state_q <= ST_SYNC;
            endcase

            if (word_done && !chan_q) begin
                left_hold_q <= word_val;
            end

            // A new pair may replace the old one on the very edge the old
            // one is accepted; otherwise it is dropped and flagged.
            if (pair_done) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_left  <= left_hold_q;
                    out_right <= word_val;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Set events take priority over a simultaneous clear.
            if (pair_done && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end

            if (short_evt) begin
                short_err <= 1'b1;
            end else if (clr_err) begin
                short_err <= 1'b0;
            end
        end
    end

    assign dbg_state = state_q;

endmodule
